// File: rtl/exe_pkg.sv
// Shared encodings for the execute stage: ALU commands, branch types, forwarding
// selects and the iterative multiplier state machine.
package exe_pkg;

    localparam logic [3:0] CmdAdd = 4'b0000;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAnd = 4'b0100;
    localparam logic [3:0] CmdOr  = 4'b0101;
    localparam logic [3:0] CmdNor = 4'b0110;
    localparam logic [3:0] CmdXor = 4'b0111;
    localparam logic [3:0] CmdSll = 4'b1000;
    localparam logic [3:0] CmdSra = 4'b1001;
    localparam logic [3:0] CmdSrl = 4'b1010;
    localparam logic [3:0] CmdMul = 4'b1100;

    localparam logic [1:0] BrNone = 2'b00;
    localparam logic [1:0] BrBez  = 2'b01;
    localparam logic [1:0] BrBne  = 2'b10;
    localparam logic [1:0] BrJmp  = 2'b11;

    localparam logic [1:0] FwdIdEx  = 2'b00;
    localparam logic [1:0] FwdMem   = 2'b01;
    localparam logic [1:0] FwdWb    = 2'b10;
    localparam logic [1:0] FwdIdEx2 = 2'b11;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

    function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                            input logic [31:0] id_val,
                                            input logic [31:0] mem_val,
                                            input logic [31:0] wb_val);
        case (sel)
            FwdMem:  return mem_val;
            FwdWb:   return wb_val;
            default: return id_val;
        endcase
    endfunction

endpackage

// File: rtl/exe_stage_mul_iter.sv
// 32-iteration shift-add multiplier; operands captured once at start, low 32 bits
// of the product presented for the single DONE cycle.
module mul_iter
    import exe_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] prod_q, prod_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            count_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    a_d     = a;
                    b_d     = b;
                    prod_d  = '0;
                    count_d = '0;
                    state_d = StBusy;
                    busy    = 1'b1;
                end
            end
            StBusy: begin
                busy = 1'b1;
                // multiplicand shifts left while the multiplier bit under test shifts out
                if (b_q[0]) prod_d = prod_q + a_q;
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                count_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
            count_d = '0;
            prod_d  = '0;
            done    = 1'b0;
        end
        if (!reset) busy = 1'b0;
    end

    assign product = prod_q;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution and the
// iterative multiplier that stalls the front of the pipeline while it runs.
module exe_stage
    import exe_pkg::*;
#(
    parameter int unsigned len = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [len-1:0] pc,
    input  logic [len-1:0] instruction,
    input  logic [3:0]     exe_cmd,
    input  logic [1:0]     branch_type,
    input  logic [31:0]    alu_inp1,
    input  logic [31:0]    alu_inp2,
    input  logic [31:0]    reg2,
    input  logic           two_regs,
    input  logic [1:0]     sel_src1,
    input  logic [1:0]     sel_src2,
    input  logic [1:0]     sel_st,
    input  logic [31:0]    mem_fwd,
    input  logic [31:0]    wb_fwd,
    input  logic           flush,
    output logic [31:0]    alu_result,
    output logic [31:0]    st_value,
    output logic           br_taken,
    output logic [len-1:0] br_addr,
    output logic           busy
);

    logic [31:0]    src1, src2, alu_out, mul_product;
    logic [4:0]     shamt;
    logic           mul_busy, mul_done, br_cond;
    logic [len-1:0] imm_ext;
    logic           unused_instr;

    assign src1     = fwd_mux(sel_src1, alu_inp1, mem_fwd, wb_fwd);
    assign src2     = fwd_mux(sel_src2, alu_inp2, mem_fwd, wb_fwd);
    assign st_value = fwd_mux(sel_st, reg2, mem_fwd, wb_fwd);
    assign shamt    = src2[4:0];

    always_comb begin
        alu_out = '0;
        case (exe_cmd)
            CmdAdd:  alu_out = src1 + src2;
            CmdSub:  alu_out = src1 - src2;
            CmdAnd:  alu_out = src1 & src2;
            CmdOr:   alu_out = src1 | src2;
            CmdNor:  alu_out = ~(src1 | src2);
            CmdXor:  alu_out = src1 ^ src2;
            CmdSll:  alu_out = src1 << shamt;
            CmdSra:  alu_out = $signed(src1) >>> shamt;
            CmdSrl:  alu_out = src1 >> shamt;
            default: alu_out = '0;
        endcase
    end

    mul_iter u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (exe_cmd == CmdMul),
        .a       (src1),
        .b       (src2),
        .abort   (flush),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign alu_result = mul_done ? mul_product : alu_out;
    assign busy       = mul_busy;

    always_comb begin
        br_cond = 1'b0;
        case (branch_type)
            BrBez:   br_cond = (src1 == 32'd0);
            BrBne:   br_cond = (src1 != (two_regs ? st_value : src2));
            BrJmp:   br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    assign br_taken     = br_cond && !flush && !busy;
    assign imm_ext      = len'($signed(instruction[15:0]));
    assign br_addr      = pc + len'(1) + imm_ext;
    assign unused_instr = ^instruction[len-1:16];

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: ALU vector table, randomized forwarding/branch
// traffic against a behavioural model, and hand-written multiplier sequences.
module tb_exe_stage;

    logic        clock, reset;
    logic [31:0] pc, instruction;
    logic [3:0]  exe_cmd;
    logic [1:0]  branch_type;
    logic [31:0] alu_inp1, alu_inp2, reg2;
    logic        two_regs;
    logic [1:0]  sel_src1, sel_src2, sel_st;
    logic [31:0] mem_fwd, wb_fwd;
    logic        flush;
    logic [31:0] alu_result, st_value, br_addr;
    logic        br_taken, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    exe_stage #(.len(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .instruction (instruction),
        .exe_cmd     (exe_cmd),
        .branch_type (branch_type),
        .alu_inp1    (alu_inp1),
        .alu_inp2    (alu_inp2),
        .reg2        (reg2),
        .two_regs    (two_regs),
        .sel_src1    (sel_src1),
        .sel_src2    (sel_src2),
        .sel_st      (sel_st),
        .mem_fwd     (mem_fwd),
        .wb_fwd      (wb_fwd),
        .flush       (flush),
        .alu_result  (alu_result),
        .st_value    (st_value),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_pick(input logic [1:0] sel, input logic [31:0] id,
                                           input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'd1) return mem;
        if (sel == 2'd2) return wb;
        return id;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] cmd, input logic [31:0] x,
                                          input logic [31:0] y);
        int unsigned sh;
        sh = y % 32;
        case (cmd)
            4'd0:    return x + y;
            4'd2:    return x - y;
            4'd4:    return x & y;
            4'd5:    return x | y;
            4'd6:    return ~(x | y);
            4'd7:    return x ^ y;
            4'd8:    return x << sh;
            4'd9:    return x[31] ? ~((~x) >> sh) : (x >> sh);
            4'd10:   return x >> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        pc = 0; instruction = 0; exe_cmd = 4'b0000; branch_type = 2'b00;
        alu_inp1 = 0; alu_inp2 = 0; reg2 = 0; two_regs = 0;
        sel_src1 = 0; sel_src2 = 0; sel_st = 0; mem_fwd = 0; wb_fwd = 0; flush = 0;
    endtask

    // Counts busy-high cycles starting from the issue cycle; returns alu_result of the
    // first non-busy cycle. Forwarding/operand inputs churn afterwards when asked.
    task automatic measure_mul(input bit churn, output int cycles, output logic [31:0] res);
        cycles = 0;
        #1;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(posedge clock);
            @(negedge clock);
            if (churn) begin
                wb_fwd = $urandom; mem_fwd = $urandom;
                alu_inp1 = $urandom; alu_inp2 = $urandom;
            end
            #1;
        end
        res = alu_result;
    endtask

    initial begin
        int          cyc;
        logic [31:0] res, a, b, s1, s2, st, exp_addr;
        logic        exp_taken;

        vecs[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        vecs[1]  = '{4'b0010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
        vecs[2]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3]  = '{4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0};
        vecs[4]  = '{4'b0110, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
        vecs[5]  = '{4'b0111, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[6]  = '{4'b1000, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[7]  = '{4'b1000, 32'h0000_0003, 32'hFFFF_FFE1, 32'h0000_0006};
        vecs[8]  = '{4'b1001, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[9]  = '{4'b1010, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[10] = '{4'b0011, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000};
        vecs[11] = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000};

        // Reset: busy stays low even with a MUL presented; ALU path is combinational.
        idle_inputs();
        reset = 1'b0;
        exe_cmd = 4'b1100;
        #3;
        check("reset_busy", 32'(busy), 32'd0);
        exe_cmd = 4'b0000; alu_inp1 = 32'd40; alu_inp2 = 32'd2;
        #1;
        check("reset_alu_follows", alu_result, 32'd42);
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        #1;
        check("post_reset_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            exe_cmd = vecs[i].cmd; alu_inp1 = vecs[i].a; alu_inp2 = vecs[i].b;
            #1;
            check($sformatf("alu_vec%0d", i), alu_result, vecs[i].exp);
            check($sformatf("alu_vec%0d_busy", i), 32'(busy), 32'd0);
        end

        // SUB with src1 forwarded from MEM.
        @(negedge clock);
        idle_inputs();
        exe_cmd = 4'b0010; sel_src1 = 2'b01; mem_fwd = 32'd10; alu_inp1 = 32'd999;
        alu_inp2 = 32'd3;
        #1;
        check("sub_mem_fwd", alu_result, 32'd7);

        // BNE against forwarded store data, backward branch target.
        @(negedge clock);
        idle_inputs();
        branch_type = 2'b10; two_regs = 1'b1; alu_inp1 = 32'd5; sel_st = 2'b10;
        wb_fwd = 32'd5; reg2 = 32'd77; pc = 32'd100; instruction = 32'h0000_FFFE;
        #1;
        check("bne_equal_taken", 32'(br_taken), 32'd0);
        wb_fwd = 32'd6;
        #1;
        check("bne_differ_taken", 32'(br_taken), 32'd1);
        check("bne_addr", br_addr, 32'd99);
        flush = 1'b1;
        #1;
        check("bne_flush_taken", 32'(br_taken), 32'd0);

        // Randomized single-cycle traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            exe_cmd = 4'($urandom_range(0, 15));
            if (exe_cmd == 4'b1100) exe_cmd = 4'b0000;
            alu_inp1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
            alu_inp2 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
            reg2     = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
            mem_fwd  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
            wb_fwd   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2));
            sel_src1 = 2'($urandom_range(0, 3));
            sel_src2 = 2'($urandom_range(0, 3));
            sel_st   = 2'($urandom_range(0, 3));
            two_regs = 1'($urandom_range(0, 1));
            branch_type = 2'($urandom_range(0, 3));
            flush    = ($urandom_range(0, 7) == 0);
            pc = $urandom; instruction = $urandom;
            #1;
            s1 = m_pick(sel_src1, alu_inp1, mem_fwd, wb_fwd);
            s2 = m_pick(sel_src2, alu_inp2, mem_fwd, wb_fwd);
            st = m_pick(sel_st, reg2, mem_fwd, wb_fwd);
            case (branch_type)
                2'd1:    exp_taken = (s1 == 0);
                2'd2:    exp_taken = two_regs ? (s1 != st) : (s1 != s2);
                2'd3:    exp_taken = 1'b1;
                default: exp_taken = 1'b0;
            endcase
            if (flush) exp_taken = 1'b0;
            exp_addr = pc + 32'd1 + {{16{instruction[15]}}, instruction[15:0]};
            check($sformatf("rnd%0d_alu", i), alu_result, m_alu(exe_cmd, s1, s2));
            check($sformatf("rnd%0d_st", i), st_value, st);
            check($sformatf("rnd%0d_taken", i), 32'(br_taken), 32'(exp_taken));
            check($sformatf("rnd%0d_addr", i), br_addr, exp_addr);
            check($sformatf("rnd%0d_busy", i), 32'(busy), 32'd0);
        end

        // MUL with src1 from WB; later forwarding changes must not matter.
        @(negedge clock);
        idle_inputs();
        exe_cmd = 4'b1100; sel_src1 = 2'b10; wb_fwd = 32'hFFFF_FFFF; alu_inp2 = 32'd3;
        branch_type = 2'b11;
        #1;
        check("mul_issue_busy", 32'(busy), 32'd1);
        check("mul_issue_jmp_blocked", 32'(br_taken), 32'd0);
        branch_type = 2'b00;
        measure_mul(1'b1, cyc, res);
        check("mul1_busy_cycles", 32'(cyc), 32'd33);
        check("mul1_product", res, 32'hFFFF_FFFD);

        // Back-to-back MUL issued the cycle after DONE.
        @(negedge clock);
        sel_src1 = 2'b00; a = $urandom; b = $urandom; alu_inp1 = a; alu_inp2 = b;
        measure_mul(1'b1, cyc, res);
        check("mul2_busy_cycles", 32'(cyc), 32'd33);
        check("mul2_product", res, a * b);
        @(negedge clock);
        exe_cmd = 4'b0000; alu_inp1 = 0; alu_inp2 = 0;
        #1;
        check("mul2_done_one_cycle", alu_result, 32'd0);
        check("mul2_after_busy", 32'(busy), 32'd0);

        // Flush in cycle 10 of a MUL, then a fresh MUL.
        @(negedge clock);
        exe_cmd = 4'b1100; alu_inp1 = 32'd12345; alu_inp2 = 32'd678;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0; exe_cmd = 4'b0000; alu_inp1 = 32'd1; alu_inp2 = 32'd2;
        #1;
        check("flush_busy_low", 32'(busy), 32'd0);
        check("flush_no_product", alu_result, 32'd3);
        @(negedge clock);
        exe_cmd = 4'b1100; alu_inp1 = 32'd7; alu_inp2 = 32'd9;
        measure_mul(1'b0, cyc, res);
        check("flush_restart_cycles", 32'(cyc), 32'd33);
        check("flush_restart_product", res, 32'd63);

        // Reset asserted in cycle 20 of a MUL.
        @(negedge clock);
        exe_cmd = 4'b1100; alu_inp1 = $urandom; alu_inp2 = $urandom;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
        #2;
        reset = 1'b0;
        #1;
        check("midmul_reset_busy", 32'(busy), 32'd0);
        exe_cmd = 4'b0111; alu_inp1 = 32'h0000_FF00; alu_inp2 = 32'h0000_0FF0;
        #1;
        check("midmul_reset_alu", alu_result, 32'h0000_F0F0);
        @(negedge clock);
        reset = 1'b1;
        exe_cmd = 4'b1100; a = $urandom; b = $urandom; alu_inp1 = a; alu_inp2 = b;
        measure_mul(1'b1, cyc, res);
        check("post_reset_mul_cycles", 32'(cyc), 32'd33);
        check("post_reset_mul_product", res, a * b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
